ram_arbiter: RTL and testbench

- Shares one single-port synchronous-write / asynchronous-read RAM (2**N words x M bits) between two requesters.
- Uses round-robin arbitration with a per-port req/gnt handshake and a registered read-response path.
- Sits between the two client blocks and the team's `ram` module, which it instantiates.
- Optional post-reset memory-clear sequencer.

---
 rtl/ram_arb_pkg.sv | 10 +
 rtl/ram.sv | 19 +
 rtl/rr_arb2.sv | 11 +
 rtl/ram_arbiter.sv | 117 +++++++++++
 tb/tb_ram_arbiter.sv | 195 +++++++++++++++++++
 5 files changed

// File: rtl/ram_arb_pkg.sv
// rtl/ram_arb_pkg.sv - shared types and constants for the two-port RAM arbiter
package ram_arb_pkg;
   typedef enum logic {INIT, RUN} state_t;

   localparam int N_DEF = 4;
   localparam int M_DEF = 16;

   localparam int REQ0 = 0;
   localparam int REQ1 = 1;
endpackage

// File: rtl/ram.sv
// rtl/ram.sv - single-port RAM, synchronous write, asynchronous read
module ram #(
   parameter int N = 4,
   parameter int M = 16
) (
   input  logic         clk,
   input  logic         we,
   input  logic [N-1:0] adr,
   input  logic [M-1:0] din,
   output logic [M-1:0] dout
);
   logic [M-1:0] mem [2**N];

   always_ff @(posedge clk) begin
      if (we) mem[adr] <= din;
   end

   assign dout = mem[adr];
endmodule

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - combinational two-way round-robin grant; prio picks the winner on contention
module rr_arb2
   import ram_arb_pkg::*;
(
   input  logic [1:0] req,
   input  logic       prio,
   output logic [1:0] gnt
);
   assign gnt[REQ0] = req[REQ0] & (~req[REQ1] | ~prio);
   assign gnt[REQ1] = req[REQ1] & (~req[REQ0] |  prio);
endmodule

// File: rtl/ram_arbiter.sv
// rtl/ram_arbiter.sv - round-robin sharing of one RAM between two requesters
// RAM_ARB_INIT_EN adds a post-reset clear of every word before requests are accepted.
module ram_arbiter
   import ram_arb_pkg::*;
#(
   parameter int N = N_DEF,
   parameter int M = M_DEF
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         req0,
   input  logic         we0,
   input  logic [N-1:0] adr0,
   input  logic [M-1:0] din0,
   output logic         gnt0,
   output logic         rvalid0,
   output logic [M-1:0] rdata0,
   input  logic         req1,
   input  logic         we1,
   input  logic [N-1:0] adr1,
   input  logic [M-1:0] din1,
   output logic         gnt1,
   output logic         rvalid1,
   output logic [M-1:0] rdata1,
   output logic         init_done
);
   state_t       state;
   logic [N-1:0] init_cnt;
   logic         prio;
   logic [1:0]   arb_gnt;
   logic         active;
   logic         clearing;
   logic         ram_we;
   logic [N-1:0] ram_adr;
   logic [M-1:0] ram_din;
   logic [M-1:0] ram_dout;

`ifdef RAM_ARB_INIT_EN
   localparam logic [N-1:0] CNT_ONE = N'(1);
   logic init_done_r;

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= INIT;
         init_cnt    <= '0;
         init_done_r <= 1'b0;
      end else if (state == INIT) begin
         init_cnt <= init_cnt + CNT_ONE;
         if (init_cnt == '1) begin
            state       <= RUN;
            init_done_r <= 1'b1;
         end
      end
   end

   assign init_done = init_done_r;
   assign clearing  = (state == INIT) & ~reset;
`else
   assign state     = RUN;
   assign init_cnt  = '0;
   assign init_done = 1'b1;
   assign clearing  = 1'b0;
`endif

   rr_arb2 u_rr_arb2 (
      .req  ({req1, req0}),
      .prio (prio),
      .gnt  (arb_gnt)
   );

   // Grants are masked in reset so a write presented during reset never lands.
   assign active = (state == RUN) & ~reset;
   assign gnt0   = active & arb_gnt[REQ0];
   assign gnt1   = active & arb_gnt[REQ1];

   always_comb begin
      ram_we  = 1'b0;
      ram_adr = adr0;
      ram_din = din0;
      if (clearing) begin
         ram_we  = 1'b1;
         ram_adr = init_cnt;
         ram_din = '0;
      end else if (gnt1) begin
         ram_we  = we1;
         ram_adr = adr1;
         ram_din = din1;
      end else if (gnt0) begin
         ram_we  = we0;
      end
   end

   ram #(.N(N), .M(M)) u_ram (
      .clk  (clk),
      .we   (ram_we),
      .adr  (ram_adr),
      .din  (ram_din),
      .dout (ram_dout)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         prio    <= 1'b0;
         rvalid0 <= 1'b0;
         rvalid1 <= 1'b0;
         rdata0  <= '0;
         rdata1  <= '0;
      end else begin
         if (gnt0)      prio <= 1'b1;
         else if (gnt1) prio <= 1'b0;
         rvalid0 <= gnt0 & ~we0;
         rvalid1 <= gnt1 & ~we1;
         if (gnt0 & ~we0) rdata0 <= ram_dout;
         if (gnt1 & ~we1) rdata1 <= ram_dout;
      end
   end
endmodule

// File: tb/tb_ram_arbiter.sv
// tb/tb_ram_arbiter.sv - directed self-checking bench for ram_arbiter
module tb_ram_arbiter;
   logic        clk = 1'b0;
   logic        reset;
   logic        req0, we0, req1, we1;
   logic [3:0]  adr0, adr1;
   logic [15:0] din0, din1;
   logic        gnt0, gnt1, rvalid0, rvalid1, init_done;
   logic [15:0] rdata0, rdata1;
   int          nchk = 0;
   int          nerr = 0;
   int          n;

   always #5 clk = ~clk;

   ram_arbiter #(.N(4), .M(16)) dut (
      .clk       (clk),
      .reset     (reset),
      .req0      (req0),
      .we0       (we0),
      .adr0      (adr0),
      .din0      (din0),
      .gnt0      (gnt0),
      .rvalid0   (rvalid0),
      .rdata0    (rdata0),
      .req1      (req1),
      .we1       (we1),
      .adr1      (adr1),
      .din1      (din1),
      .gnt1      (gnt1),
      .rvalid1   (rvalid1),
      .rdata1    (rdata1),
      .init_done (init_done)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      nchk++;
      if (got !== exp) begin
         nerr++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset = 1'b1;
      req0 = 1'b0; we0 = 1'b0; adr0 = '0; din0 = '0;
      req1 = 1'b0; we1 = 1'b0; adr1 = '0; din1 = '0;
      repeat (3) tick;
      reset = 1'b0;
`ifdef RAM_ARB_INIT_EN
      n = 0;
      while (!init_done && n < 40) begin
         tick;
         n++;
      end
      chk("init_cycles", n, 16);
`endif
      #1;
      chk("rst_gnt0", gnt0, 0);
      chk("rst_gnt1", gnt1, 0);
      chk("rst_rvalid0", rvalid0, 0);
      chk("rst_rvalid1", rvalid1, 0);
      chk("rst_rdata0", rdata0, 0);
      chk("rst_rdata1", rdata1, 0);
      chk("rst_init_done", init_done, 1);
`ifdef RAM_ARB_INIT_EN
      req0 = 1'b1; we0 = 1'b0; adr0 = 4'd7;
      #1 chk("clr_gnt0", gnt0, 1);
      tick;
      req0 = 1'b0;
      chk("clr_rdata0", rdata0, 16'h0000);
`endif

      // port 0 write then read of the same address
      req0 = 1'b1; we0 = 1'b1; adr0 = 4'd3; din0 = 16'hBEEF;
      #1 chk("wr_gnt0", gnt0, 1);
      tick;
      chk("wr_no_rvalid0", rvalid0, 0);
      we0 = 1'b0;
      #1 chk("rd_gnt0", gnt0, 1);
      tick;
      req0 = 1'b0;
      chk("rd_rvalid0", rvalid0, 1);
      chk("rd_rdata0", rdata0, 16'hBEEF);
      chk("rd_rvalid1", rvalid1, 0);
      tick;
      chk("rd_rvalid0_pulse", rvalid0, 0);
      chk("rd_rdata0_hold", rdata0, 16'hBEEF);

      // preload: port 0 gets adr 1, then port 1 gets adr 2 (prio returns to 0)
      req0 = 1'b1; we0 = 1'b1; adr0 = 4'd1; din0 = 16'h1111;
      tick;
      req0 = 1'b0;
      req1 = 1'b1; we1 = 1'b1; adr1 = 4'd2; din1 = 16'h2222;
      tick;
      req1 = 1'b0;

      // both ports read every cycle -> alternate 0,1,0,1
      req0 = 1'b1; we0 = 1'b0; adr0 = 4'd1;
      req1 = 1'b1; we1 = 1'b0; adr1 = 4'd2;
      for (int i = 0; i < 4; i++) begin
         #1;
         chk("alt_gnt0", gnt0, (i % 2 == 0));
         chk("alt_gnt1", gnt1, (i % 2 == 1));
         if (i > 0) begin
            if ((i - 1) % 2 == 0) begin
               chk("alt_rvalid0", rvalid0, 1);
               chk("alt_rdata0", rdata0, 16'h1111);
            end else begin
               chk("alt_rvalid1", rvalid1, 1);
               chk("alt_rdata1", rdata1, 16'h2222);
            end
         end
         tick;
      end
      req0 = 1'b0; req1 = 1'b0;
      chk("alt_last_rvalid1", rvalid1, 1);
      chk("alt_last_rdata1", rdata1, 16'h2222);

      // same-cycle write (port 0) and read (port 1) of adr 5
      req0 = 1'b1; we0 = 1'b1; adr0 = 4'd5; din0 = 16'hAAAA;
      req1 = 1'b1; we1 = 1'b0; adr1 = 4'd5;
      #1;
      chk("wr_rd_gnt0", gnt0, 1);
      chk("wr_rd_gnt1_wait", gnt1, 0);
      tick;
      req0 = 1'b0;
      #1 chk("wr_rd_gnt1", gnt1, 1);
      tick;
      req1 = 1'b0;
      chk("wr_rd_rvalid1", rvalid1, 1);
      chk("wr_rd_rdata1", rdata1, 16'hAAAA);

      // port 1 alone: three consecutive writes
      for (int i = 0; i < 3; i++) begin
         req1 = 1'b1; we1 = 1'b1; adr1 = 4'(8 + i); din1 = 16'(16'h5000 + i);
         #1 chk("p1_burst_gnt1", gnt1, 1);
         tick;
      end
      req1 = 1'b0;

      // prio must be back at 0: port 0 wins the contention
      req0 = 1'b1; we0 = 1'b0; adr0 = 4'd8;
      req1 = 1'b1; we1 = 1'b0; adr1 = 4'd9;
      #1 chk("prio0_gnt0", gnt0, 1);
      tick;
      req0 = 1'b0;
      chk("burst_rdata0", rdata0, 16'h5000);
      #1 chk("prio0_gnt1", gnt1, 1);
      tick;
      req1 = 1'b0;
      chk("burst_rdata1", rdata1, 16'h5001);

      // reset in the cycle after a port 1 read grant, with a write pending on port 0
      req1 = 1'b1; we1 = 1'b0; adr1 = 4'd2;
      #1 chk("pre_rst_gnt1", gnt1, 1);
      tick;
      req1 = 1'b0;
      reset = 1'b1;
      req0 = 1'b1; we0 = 1'b1; adr0 = 4'd2; din0 = 16'hDEAD;
      #1;
      chk("rst_cycle_rvalid1", rvalid1, 1);
      chk("rst_cycle_gnt0", gnt0, 0);
      tick;
      reset = 1'b0;
      we0 = 1'b0;
      chk("rst_cancel_rvalid1", rvalid1, 0);
      chk("rst_clear_rdata1", rdata1, 0);
`ifdef RAM_ARB_INIT_EN
      n = 0;
      #1;
      while (!gnt0 && n < 40) begin
         tick;
         n++;
      end
      chk("rst_init_blocked", n, 16);
      tick;
      req0 = 1'b0;
      chk("rst_cleared_rdata0", rdata0, 16'h0000);
`else
      #1 chk("post_rst_gnt0", gnt0, 1);
      tick;
      req0 = 1'b0;
      chk("rst_kept_rdata0", rdata0, 16'h2222);
`endif

      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end
endmodule
